// File: rtl/fft_128.sv
// 128-point radix-2 DIT FFT: captures 128 real samples, transforms them in place in a
// single-port RAM with one 6-cycle butterfly at a time, then streams the bins in natural order.

module ram128 (
    input  logic        clock,
    input  logic [6:0]  address,
    input  logic [15:0] data,
    input  logic        wren,
    output logic [15:0] q
);
    logic [15:0] mem [128];

    // Registered read; a write and a read of the same word return the old contents.
    always_ff @(posedge clock) begin
        if (wren) mem[address] <= data;
        q <= mem[address];
    end
endmodule

module fft_128 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data1,
    input  logic        fft_go,
    output logic        fft_done,
    output logic [15:0] fft_res
);
    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StOut} state_e;
    typedef enum logic [2:0] {PhRa, PhRb, PhWait, PhCalc, PhWa, PhWb} phase_e;

    state_e      state_q, state_d;
    phase_e      ph_q, ph_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  stage_q, stage_d;
    logic [5:0]  bfly_q, bfly_d;
    logic [15:0] a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d;
    logic        rd_v_q, rd_v_d;
    logic        done_q;
    logic [15:0] res_q;

    logic [6:0]  ram_addr;
    logic [15:0] ram_wdata, ram_q;
    logic        ram_wren;

    logic [6:0]  span, bf_k, bf_a, bf_b, load_addr;
    logic [5:0]  tw_idx;

    logic signed [7:0]  ar, ai, br, bi, wr, wi, xr, xi, yr, yi;
    logic signed [15:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [9:0]  pr, pim, ar10, ai10;

    // round(64 * cos(pi * t / 64)) for t = 0..32; other twiddles follow by symmetry.
    function automatic logic [7:0] cos_q(input logic [5:0] t);
        case (t)
            6'd0:  return 8'd64;  6'd1:  return 8'd64;  6'd2:  return 8'd64;
            6'd3:  return 8'd63;  6'd4:  return 8'd63;  6'd5:  return 8'd62;
            6'd6:  return 8'd61;  6'd7:  return 8'd60;  6'd8:  return 8'd59;
            6'd9:  return 8'd58;  6'd10: return 8'd56;  6'd11: return 8'd55;
            6'd12: return 8'd53;  6'd13: return 8'd51;  6'd14: return 8'd49;
            6'd15: return 8'd47;  6'd16: return 8'd45;  6'd17: return 8'd43;
            6'd18: return 8'd41;  6'd19: return 8'd38;  6'd20: return 8'd36;
            6'd21: return 8'd33;  6'd22: return 8'd30;  6'd23: return 8'd27;
            6'd24: return 8'd24;  6'd25: return 8'd22;  6'd26: return 8'd19;
            6'd27: return 8'd16;  6'd28: return 8'd12;  6'd29: return 8'd9;
            6'd30: return 8'd6;   6'd31: return 8'd3;
            default: return 8'd0;
        endcase
    endfunction

    ram128 u_ram (
        .clock   (clk),
        .address (ram_addr),
        .data    (ram_wdata),
        .wren    (ram_wren),
        .q       (ram_q)
    );

    assign load_addr = {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3], cnt_q[4], cnt_q[5], cnt_q[6]};

    assign span   = 7'd1 << stage_q;
    assign bf_k   = {1'b0, bfly_q} & (span - 7'd1);
    assign bf_a   = (({1'b0, bfly_q} >> stage_q) << (stage_q + 3'd1)) | bf_k;
    assign bf_b   = bf_a + span;
    assign tw_idx = bf_k[5:0] << (3'd6 - stage_q);

    always_comb begin
        if (tw_idx <= 6'd32) begin
            wr = cos_q(tw_idx);
            wi = 8'd0 - cos_q(6'd32 - tw_idx);
        end else begin
            wr = 8'd0 - cos_q(6'd0 - tw_idx);
            wi = 8'd0 - cos_q(tw_idx - 6'd32);
        end
    end

    assign ar   = a_q[15:8];
    assign ai   = a_q[7:0];
    assign br   = b_q[15:8];
    assign bi   = b_q[7:0];
    assign p_rr = br * wr;
    assign p_ii = bi * wi;
    assign p_ri = br * wi;
    assign p_ir = bi * wr;
    assign pr   = 10'((p_rr - p_ii) >>> 6);
    assign pim  = 10'((p_ri + p_ir) >>> 6);
    assign ar10 = {{2{ar[7]}}, ar};
    assign ai10 = {{2{ai[7]}}, ai};
    // Halving every stage keeps the result inside 8 bits.
    assign xr   = 8'((ar10 + pr) >>> 1);
    assign xi   = 8'((ai10 + pim) >>> 1);
    assign yr   = 8'((ar10 - pr) >>> 1);
    assign yi   = 8'((ai10 - pim) >>> 1);

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        bfly_d    = bfly_q;
        a_d       = a_q;
        b_d       = b_q;
        x_d       = x_q;
        y_d       = y_q;
        rd_v_d    = 1'b0;
        ram_addr  = bf_a;
        ram_wdata = x_q;
        ram_wren  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fft_go) begin
                    state_d = StLoad;
                    cnt_d   = 8'd0;
                end
            end
            StLoad: begin
                ram_addr  = load_addr;
                ram_wdata = {data1, 8'd0};
                ram_wren  = 1'b1;
                cnt_d     = cnt_q + 8'd1;
                if (cnt_q[6:0] == 7'd127) begin
                    state_d = StCalc;
                    cnt_d   = 8'd0;
                    stage_d = 3'd0;
                    bfly_d  = 6'd0;
                    ph_d    = PhRa;
                end
            end
            StCalc: begin
                unique case (ph_q)
                    PhRa: ph_d = PhRb;
                    PhRb: begin
                        ram_addr = bf_b;
                        a_d      = ram_q;
                        ph_d     = PhWait;
                    end
                    PhWait: begin
                        ram_addr = bf_b;
                        b_d      = ram_q;
                        ph_d     = PhCalc;
                    end
                    PhCalc: begin
                        x_d  = {xr, xi};
                        y_d  = {yr, yi};
                        ph_d = PhWa;
                    end
                    PhWa: begin
                        ram_wren = 1'b1;
                        ph_d     = PhWb;
                    end
                    PhWb: begin
                        ram_addr  = bf_b;
                        ram_wdata = y_q;
                        ram_wren  = 1'b1;
                        ph_d      = PhRa;
                        bfly_d    = bfly_q + 6'd1;
                        if (bfly_q == 6'd63) begin
                            stage_d = stage_q + 3'd1;
                            if (stage_q == 3'd6) begin
                                state_d = StOut;
                                cnt_d   = 8'd0;
                            end
                        end
                    end
                    default: ph_d = PhRa;
                endcase
            end
            StOut: begin
                // One extra drain cycle so the last bin leaves before going idle.
                ram_addr = cnt_q[6:0];
                rd_v_d   = ~cnt_q[7];
                cnt_d    = cnt_q + 8'd1;
                if (cnt_q[7]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ph_q    <= PhRa;
            cnt_q   <= 8'd0;
            stage_q <= 3'd0;
            bfly_q  <= 6'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
            rd_v_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rd_v_q  <= rd_v_d;
            done_q  <= rd_v_q;
            res_q   <= rd_v_q ? ram_q : 16'd0;
        end
    end

    assign fft_done = done_q;
    assign fft_res  = res_q;
endmodule

// File: tb/tb_fft_128.sv
// Bench for fft_128: a fixed-point DFT reference fills a scoreboard queue; a monitor checks
// every output cycle, the output window timing, and reset behaviour.

module tb_fft_128;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data1;
    logic        fft_go;
    logic        fft_done;
    logic [15:0] fft_res;

    always #5 clk = ~clk;

    fft_128 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data1    (data1),
        .fft_go   (fft_go),
        .fft_done (fft_done),
        .fft_res  (fft_res)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          go_edge = 0;
    int          xin [128];
    logic [15:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    function automatic int wrap8(input int v);
        byte b8;
        b8 = byte'(v);
        return int'(b8);
    endfunction

    function automatic int rev7(input int n);
        int r = 0;
        for (int i = 0; i < 7; i++) if (((n >> i) & 1) != 0) r |= 1 << (6 - i);
        return r;
    endfunction

    // Fixed-point radix-2 DIT reference: Q1.6 twiddles, floor shifts, halving every stage.
    task automatic build_expected();
        int  re [128];
        int  im [128];
        int  h, g, k, a, b, t, wr, wi, pr, pim, xr, xi, yr, yi;
        real ang;
        for (int n = 0; n < 128; n++) begin
            re[rev7(n)] = xin[n];
            im[rev7(n)] = 0;
        end
        for (int s = 0; s < 7; s++) begin
            h = 1 << s;
            for (int j = 0; j < 64; j++) begin
                g   = j >> s;
                k   = j & (h - 1);
                a   = g * 2 * h + k;
                b   = a + h;
                t   = k * (64 >> s);
                ang = 2.0 * PI * t / 128.0;
                wr  = rnd(64.0 * $cos(ang));
                wi  = rnd(-64.0 * $sin(ang));
                pr  = (re[b] * wr - im[b] * wi) >>> 6;
                pim = (re[b] * wi + im[b] * wr) >>> 6;
                xr  = wrap8((re[a] + pr) >>> 1);
                xi  = wrap8((im[a] + pim) >>> 1);
                yr  = wrap8((re[a] - pr) >>> 1);
                yi  = wrap8((im[a] - pim) >>> 1);
                re[a] = xr; im[a] = xi; re[b] = yr; im[b] = yi;
            end
        end
        for (int n = 0; n < 128; n++) exp_q.push_back({re[n][7:0], im[n][7:0]});
    endtask

    task automatic start_run(input bit expect_out);
        if (expect_out) build_expected();
        @(negedge clk);
        fft_go = 1'b1;
        @(posedge clk);
        #1 go_edge = cyc;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            fft_go = 1'b0;
            data1  = xin[i][7:0];
        end
    endtask

    // Returns as soon as the last bin has been consumed, so the next go lands on the
    // first edge at which it may be accepted.
    task automatic wait_done();
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL run_timeout bins_left=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 128; i++) xin[i] = int'($urandom_range(255, 0)) - 128;
    endtask

    logic        done_prev = 1'b0;
    int          run_len = 0;
    logic [15:0] exp_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            done_prev = 1'b0;
            run_len   = 0;
        end else begin
            if (fft_done) begin
                if (!done_prev) begin
                    total++;
                    if (cyc - go_edge != 2818) begin
                        bad++;
                        $display("FAIL done_rise got=%0d required=2818", cyc - go_edge);
                    end
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_bin res=%h required=no_output", fft_res);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (fft_res !== exp_w) begin
                        bad++;
                        $display("FAIL bin%0d got=%h required=%h", run_len, fft_res, exp_w);
                    end
                end
                run_len++;
            end else begin
                if (done_prev) begin
                    total++;
                    if (run_len != 128) begin
                        bad++;
                        $display("FAIL done_width got=%0d required=128", run_len);
                    end
                    run_len = 0;
                end
                total++;
                if (fft_res !== 16'h0000) begin
                    bad++;
                    $display("FAIL res_idle got=%h required=0000", fft_res);
                end
            end
            done_prev = fft_done;
        end
    end

    initial begin
        rst_n  = 1'b0;
        fft_go = 1'b0;
        data1  = 8'd0;
        repeat (3) @(negedge clk);
        total += 2;
        if (fft_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b required=0", fft_done); end
        if (fft_res !== 16'h0) begin bad++; $display("FAIL reset_res got=%h required=0000", fft_res); end
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 128; i++) xin[i] = 0;
        start_run(1'b1); wait_done();
        for (int i = 0; i < 128; i++) xin[i] = 64;
        start_run(1'b1); wait_done();
        for (int i = 0; i < 128; i++) xin[i] = (i == 0) ? 127 : 0;
        start_run(1'b1); wait_done();
        for (int i = 0; i < 128; i++) xin[i] = (i % 2 == 0) ? 64 : -64;
        start_run(1'b1); wait_done();
        fill_random(); start_run(1'b1); wait_done();
        fill_random(); start_run(1'b1); wait_done();

        // A second go while the transform runs must be ignored.
        fill_random(); start_run(1'b1);
        repeat (600) @(negedge clk);
        fft_go = 1'b1;
        @(negedge clk);
        fft_go = 1'b0;
        wait_done();

        // Reset in the middle of the output stream clears the outputs at once.
        fill_random(); start_run(1'b1);
        for (int i = 0; i < 3200 && exp_q.size() > 60; i++) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total += 2;
        if (fft_done !== 1'b0) begin bad++; $display("FAIL rst_out_done got=%b required=0", fft_done); end
        if (fft_res !== 16'h0) begin bad++; $display("FAIL rst_out_res got=%h required=0000", fft_res); end
        exp_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;

        // One-cycle reset mid-CALC: no output stream may follow.
        fill_random(); start_run(1'b0);
        repeat (1000) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total += 2;
        if (fft_done !== 1'b0) begin bad++; $display("FAIL rst_calc_done got=%b required=0", fft_done); end
        if (fft_res !== 16'h0) begin bad++; $display("FAIL rst_calc_res got=%h required=0000", fft_res); end
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3000) @(negedge clk);

        fill_random(); start_run(1'b1); wait_done();
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
